// File: rtl/wb_port_arbiter.sv
// Write-port arbiter for the register file: the pipeline source has fixed priority,
// the load and mul/div sources share the remaining slots round-robin, and a starvation guard protects them.
module wb_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s2_valid,
  output logic              s2_ready,
  input  logic [ADDR_W-1:0] s2_addr,
  input  logic [DATA_W-1:0] s2_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        grant
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  logic              rr_two;    // 0: rr_ptr names source 1, 1: rr_ptr names source 2
  logic [CNT_W-1:0]  cnt1, cnt2;
  logic              starve1, starve2;
  logic [2:0]        win;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // A counter only saturates while its source keeps valid high, so gating with valid is a safety net.
  assign starve1 = s1_valid && (cnt1 == LIMIT);
  assign starve2 = s2_valid && (cnt2 == LIMIT);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win = 3'b000;
    if (!reset) begin
      if (starve1 && starve2)      win = rr_two ? 3'b100 : 3'b010;
      else if (starve1)            win = 3'b010;
      else if (starve2)            win = 3'b100;
      else if (s0_valid)           win = 3'b001;
      else if (s1_valid && s2_valid) win = rr_two ? 3'b100 : 3'b010;
      else if (s1_valid)           win = 3'b010;
      else if (s2_valid)           win = 3'b100;
    end
  end

  assign s0_ready = win[0];
  assign s1_ready = win[1];
  assign s2_ready = win[2];
  assign xfer     = |win;

  always_comb begin
    win_addr = s0_addr;
    win_data = s0_data;
    if (win[1]) begin
      win_addr = s1_addr;
      win_data = s1_data;
    end else if (win[2]) begin
      win_addr = s2_addr;
      win_data = s2_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_two <= 1'b0;
      cnt1   <= '0;
      cnt2   <= '0;
    end else begin
      if (win[1])      rr_two <= 1'b1;
      else if (win[2]) rr_two <= 1'b0;

      if (!s1_valid || win[1]) cnt1 <= '0;
      else if (cnt1 != LIMIT)  cnt1 <= cnt1 + CNT_W'(1);

      if (!s2_valid || win[2]) cnt2 <= '0;
      else if (cnt2 != LIMIT)  cnt2 <= cnt2 + CNT_W'(1);
    end
  end

  // Register $0 is hard-wired: the handshake and grant still happen, only the write enable is suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant    <= 3'b000;
    end else begin
      rf_we <= xfer && (win_addr != '0);
      grant <= win;
      if (xfer) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter with hand-computed expectations
// plus hand-written starvation and reset-during-wait sequences.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_valid, s1_valid, s2_valid;
  logic        s0_ready, s1_ready, s2_ready;
  logic [2:0]  s0_addr, s1_addr, s2_addr;
  logic [15:0] s0_data, s1_data, s2_data;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [2:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_addr(s2_addr), .s2_data(s2_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant(grant)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  v;      // {s2, s1, s0} valid
    logic [2:0]  a0, a1, a2;
    logic [15:0] d0, d1, d2;
    logic [2:0]  rdy;    // expected {s2, s1, s0} ready in this cycle
    logic        we;     // expected registered outputs after the edge
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  gnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 unit after a rising edge; ready is sampled mid-cycle, registers 1 unit after the next edge.
  task automatic apply_vec(input vec_t t, input string name);
    reset    = t.rst;
    s0_valid = t.v[0]; s1_valid = t.v[1]; s2_valid = t.v[2];
    s0_addr  = t.a0;   s1_addr  = t.a1;   s2_addr  = t.a2;
    s0_data  = t.d0;   s1_data  = t.d1;   s2_data  = t.d2;
    #3;
    check({name, " ready"}, 32'({s2_ready, s1_ready, s0_ready}), 32'(t.rdy));
    @(posedge clk);
    #1;
    check({name, " rf_we"},    32'(rf_we),    32'(t.we));
    check({name, " rf_waddr"}, 32'(rf_waddr), 32'(t.waddr));
    check({name, " rf_wdata"}, 32'(rf_wdata), 32'(t.wdata));
    check({name, " grant"},    32'(grant),    32'(t.gnt));
  endtask

  function automatic vec_t mk(input logic rst, input logic [2:0] v,
                              input logic [2:0] a0, input logic [15:0] d0,
                              input logic [2:0] a1, input logic [15:0] d1,
                              input logic [2:0] a2, input logic [15:0] d2,
                              input logic [2:0] rdy, input logic we,
                              input logic [2:0] waddr, input logic [15:0] wdata,
                              input logic [2:0] gnt);
    vec_t t;
    t.rst = rst; t.v = v;
    t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1; t.a2 = a2; t.d2 = d2;
    t.rdy = rdy; t.we = we; t.waddr = waddr; t.wdata = wdata; t.gnt = gnt;
    return t;
  endfunction

  vec_t vecs[13];

  // Pipeline source busy every cycle; secondaries requested per 'v'. Expected grant index per cycle is given.
  task automatic run_starve(input string tag, input int ncyc, input int g1_cyc, input int g2_cyc);
    logic [2:0] v;
    logic [2:0] g;
    logic [2:0] ea;
    logic [15:0] ed;
    for (int c = 0; c < ncyc; c++) begin
      v = 3'b001;
      if (g1_cyc >= 0 && c <= g1_cyc) v[1] = 1'b1;
      if (g2_cyc >= 0 && c <= g2_cyc) v[2] = 1'b1;
      if (c == g1_cyc)      begin g = 3'b010; ea = 3'd5; ed = 16'h5555; end
      else if (c == g2_cyc) begin g = 3'b100; ea = 3'd6; ed = 16'h6666; end
      else                  begin g = 3'b001; ea = 3'd1; ed = 16'h0100 + 16'(c); end
      apply_vec(mk(1'b0, v, 3'd1, 16'h0100 + 16'(c), 3'd5, 16'h5555, 3'd6, 16'h6666,
                   g, 1'b1, ea, ed, g), $sformatf("%s c%0d", tag, c));
    end
  endtask

  task automatic do_reset(input string tag);
    apply_vec(mk(1'b1, 3'b000, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 16'h0,
                 3'b000, 1'b0, 3'd0, 16'h0, 3'b000), tag);
  endtask

  initial begin
    //               rst  v       a0    d0        a1    d1        a2    d2        rdy     we    waddr wdata     gnt
    vecs[0]  = mk(1'b1, 3'b111, 3'd3, 16'h1234, 3'd5, 16'hAAAA, 3'd6, 16'hBBBB, 3'b000, 1'b0, 3'd0, 16'h0000, 3'b000);
    vecs[1]  = mk(1'b1, 3'b111, 3'd3, 16'h1234, 3'd5, 16'hAAAA, 3'd6, 16'hBBBB, 3'b000, 1'b0, 3'd0, 16'h0000, 3'b000);
    vecs[2]  = mk(1'b0, 3'b111, 3'd3, 16'h1234, 3'd5, 16'hAAAA, 3'd6, 16'hBBBB, 3'b001, 1'b1, 3'd3, 16'h1234, 3'b001);
    // Round-robin between the secondaries with s0 idle: 1,2,1,2
    vecs[3]  = mk(1'b0, 3'b110, 3'd0, 16'h0000, 3'd1, 16'h1111, 3'd2, 16'h2222, 3'b010, 1'b1, 3'd1, 16'h1111, 3'b010);
    vecs[4]  = mk(1'b0, 3'b110, 3'd0, 16'h0000, 3'd4, 16'h4444, 3'd2, 16'h2222, 3'b100, 1'b1, 3'd2, 16'h2222, 3'b100);
    vecs[5]  = mk(1'b0, 3'b110, 3'd0, 16'h0000, 3'd4, 16'h4444, 3'd7, 16'h7777, 3'b010, 1'b1, 3'd4, 16'h4444, 3'b010);
    vecs[6]  = mk(1'b0, 3'b110, 3'd0, 16'h0000, 3'd5, 16'h5555, 3'd7, 16'h7777, 3'b100, 1'b1, 3'd7, 16'h7777, 3'b100);
    // $0 write: handshake and grant, no write enable, payload still captured
    vecs[7]  = mk(1'b0, 3'b100, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 16'hFFFF, 3'b100, 1'b0, 3'd0, 16'hFFFF, 3'b100);
    // Idle holds address/data
    vecs[8]  = mk(1'b0, 3'b000, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'b000, 1'b0, 3'd0, 16'hFFFF, 3'b000);
    // Same source back to back, then s2, then s0
    vecs[9]  = mk(1'b0, 3'b010, 3'd0, 16'h0000, 3'd6, 16'h6666, 3'd0, 16'h0000, 3'b010, 1'b1, 3'd6, 16'h6666, 3'b010);
    vecs[10] = mk(1'b0, 3'b010, 3'd0, 16'h0000, 3'd2, 16'h0202, 3'd0, 16'h0000, 3'b010, 1'b1, 3'd2, 16'h0202, 3'b010);
    vecs[11] = mk(1'b0, 3'b100, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd3, 16'h0303, 3'b100, 1'b1, 3'd3, 16'h0303, 3'b100);
    vecs[12] = mk(1'b0, 3'b001, 3'd7, 16'h0707, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'b001, 1'b1, 3'd7, 16'h0707, 3'b001);

    for (int i = 0; i < 13; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Single starvation: s1 forced through in cycle 4 with s0_ready low, s0 resumes in cycle 5.
    do_reset("starve rst");
    run_starve("starve", 7, 4, -1);

    // Double starvation: s1 first (rr_ptr=1), s2 in the very next cycle.
    do_reset("dstarve rst");
    run_starve("dstarve", 7, 4, 5);

    // Reset while s1 has waited 3 cycles: count is lost, full wait restarts.
    do_reset("midrst rst0");
    for (int c = 0; c < 3; c++)
      apply_vec(mk(1'b0, 3'b011, 3'd1, 16'h0900 + 16'(c), 3'd5, 16'h5555, 3'd0, 16'h0,
                   3'b001, 1'b1, 3'd1, 16'h0900 + 16'(c), 3'b001), $sformatf("midrst pre%0d", c));
    apply_vec(mk(1'b1, 3'b011, 3'd1, 16'h0999, 3'd5, 16'h5555, 3'd0, 16'h0,
                 3'b000, 1'b0, 3'd0, 16'h0000, 3'b000), "midrst rst");
    run_starve("midrst post", 6, 4, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
